csa_mp_seq: RTL and testbench
=============================

// Module: csa_mp_seq
// PURPOSE
//  Multi-precision add/subtract sequencer built around one CSA #(dataWidth,nStage) instance.
//  Accepts a command (op, limb count), then streams operand limbs LS-first through the CSA.
//  Carry is chained between limbs in a register; one result limb is produced per accepted limb.
//  Sits between the big-integer operand buffers and the result buffer; only owner of the CSA.
// PARAMETERS
//  dataWidth  32  limb width; passed to CSA; must be a multiple of nStage
//  nStage     4   CSA select stages
//  maxLimbs   8   max limbs per command; nlW = $clog2(maxLimbs+1)
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          async reset, active low
//  cmd_valid  in   1          command valid
//  cmd_ready  out  1          command accepted when valid&ready
//  cmd_sub    in   1          0: A+B, 1: A-B
//  cmd_nlimbs in   nlW        limbs in operation
//  in_valid   in   1          operand limb valid
//  in_ready   out  1          operand limb accepted when valid&ready
//  in_a       in   dataWidth  operand A limb
//  in_b       in   dataWidth  operand B limb
//  out_valid  out  1          result limb valid
//  out_ready  in   1          result limb consumed when valid&ready
//  out_s      out  dataWidth  result limb
//  out_last   out  1          marks final limb of the command
//  out_co     out  1          final carry (add) / no-borrow (sub); valid only with out_last
//  out_ovf    out  1          signed overflow of full-width result; valid only with out_last
//  busy       out  1          state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, out_last, out_co, out_ovf, busy = 0; out_s = 0; carry = 0; limb count = 0.
//  FSM: IDLE -(cmd hs)-> RUN -(last limb in hs)-> DRAIN -(out hs of last limb)-> IDLE.
//  cmd_ready = (state==IDLE). At cmd hs: latch sub, carry <= cmd_sub, remaining <= clamp(cmd_nlimbs).
//  clamp: 0 -> 1, >maxLimbs -> maxLimbs. Other values unchanged.
//  Limb op: CSA(a=in_a, b=in_b ^ {dataWidth{sub}}, ci=carry); combinational, registered on in hs.
//  in_ready = (state==RUN) && (!out_valid || out_ready); single-entry output register, full throughput.
//  On in hs: out_s <= CSA.s; carry <= CSA.co; out_valid <= 1; remaining decrements.
//    out_last <= (remaining==1).
//  On the last limb, also: out_co <= CSA.co; out_ovf <= (a_msb==b'_msb) && (s_msb!=a_msb).
//    b' = in_b ^ {dataWidth{sub}}.
//  On non-last limbs, out_co = out_ovf = 0.
//  Latency: in hs -> out_valid next cycle. out_* hold stable while out_valid && !out_ready.
//  out_valid clears on out hs unless a new in hs occurs in the same cycle (back-to-back).
//  in_valid in IDLE/DRAIN: ignored, in_ready=0. cmd_valid in RUN/DRAIN: ignored, cmd_ready=0.
//  Next cmd is accepted only after the last limb leaves (IDLE); no overlap between commands.
//  Reset mid-operation: all state discarded immediately; no partial result is emitted after reset.
// TESTING
//  T1 add, nlimbs=2, A=0xFFFFFFFF_FFFFFFFF, B=0x1
//     -> out_s 0x0 (last=0), then 0x0 (last=1); out_co=1, out_ovf=0.
//  T2 sub, nlimbs=1, A=5, B=7 -> out_s=0xFFFFFFFE, out_last=1, out_co=0, out_ovf=0.
//  T3 add, nlimbs=1, A=0x7FFFFFFF, B=0x1 -> out_s=0x80000000, out_co=0, out_ovf=1.
//  T4 add, nlimbs=4, out_ready held low 3 cycles mid-stream
//     -> in_ready=0 while stalled; out_s stable; 4 limbs delivered in order, no loss/dup.
//  T5 cmd_nlimbs=0 -> exactly 1 result limb with out_last=1;
//     cmd_nlimbs=15 (maxLimbs=8) -> exactly 8 limbs.
//  T6 rst_n low after 2 of 4 limbs -> all outputs 0 next edge, state IDLE;
//     new cmd then behaves as from fresh reset.

Source files
------------

// File: rtl/csa_mp_seq.sv
// Multi-precision add/subtract sequencer: one limb per accepted input, carry chained in a register.
// Latency 1 cycle input->output; in_ready drops while the single output register is held by out_ready=0.

module csa #(
    parameter int dataWidth = 32,
    parameter int nStage    = 4
) (
    input  logic [dataWidth-1:0] a,
    input  logic [dataWidth-1:0] b,
    input  logic                 ci,
    output logic [dataWidth-1:0] s,
    output logic                 co
);
    localparam int SW = dataWidth / nStage;

    logic [nStage:0] c;
    assign c[0] = ci;

    // Each stage precomputes both carry-in outcomes; the incoming carry only drives a mux.
    for (genvar g = 0; g < nStage; g++) begin : g_stage
        logic [SW:0] sum0;
        logic [SW:0] sum1;
        assign sum0 = {1'b0, a[g*SW +: SW]} + {1'b0, b[g*SW +: SW]};
        assign sum1 = {1'b0, a[g*SW +: SW]} + {1'b0, b[g*SW +: SW]} + {{SW{1'b0}}, 1'b1};
        assign s[g*SW +: SW] = c[g] ? sum1[SW-1:0] : sum0[SW-1:0];
        assign c[g+1]        = c[g] ? sum1[SW]     : sum0[SW];
    end

    assign co = c[nStage];
endmodule

module csa_mp_seq #(
    parameter int  dataWidth = 32,
    parameter int  nStage    = 4,
    parameter int  maxLimbs  = 8,
    localparam int nlW       = $clog2(maxLimbs + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_sub,
    input  logic [nlW-1:0]       cmd_nlimbs,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [dataWidth-1:0] in_a,
    input  logic [dataWidth-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [dataWidth-1:0] out_s,
    output logic                 out_last,
    output logic                 out_co,
    output logic                 out_ovf,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [nlW-1:0] MAXL = nlW'(maxLimbs);
    localparam logic [nlW-1:0] ONE  = nlW'(1);

    state_t               state_q, state_d;
    logic                 sub_q, sub_d;
    logic                 carry_q, carry_d;
    logic [nlW-1:0]       rem_q, rem_d;
    logic [dataWidth-1:0] out_s_q, out_s_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 out_co_q, out_co_d;
    logic                 out_ovf_q, out_ovf_d;

    logic [dataWidth-1:0] b_eff;
    logic [dataWidth-1:0] csa_s;
    logic                 csa_co;
    logic [nlW-1:0]       nl_clamped;
    logic                 cmd_hs, in_hs, out_hs, is_last;

    assign b_eff = in_b ^ {dataWidth{sub_q}};

    csa #(.dataWidth(dataWidth), .nStage(nStage)) u_csa (
        .a  (in_a),
        .b  (b_eff),
        .ci (carry_q),
        .s  (csa_s),
        .co (csa_co)
    );

    assign cmd_ready = (state_q == IDLE);
    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign busy      = (state_q != IDLE);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign is_last   = (rem_q == ONE);

    always_comb begin
        nl_clamped = cmd_nlimbs;
        if (cmd_nlimbs == '0) begin
            nl_clamped = ONE;
        end else if (cmd_nlimbs > MAXL) begin
            nl_clamped = MAXL;
        end
    end

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        rem_d       = rem_q;
        out_s_d     = out_s_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_co_d    = out_co_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    state_d = RUN;
                    sub_d   = cmd_sub;
                    carry_d = cmd_sub;
                    rem_d   = nl_clamped;
                end
            end
            RUN: begin
                if (in_hs && is_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (out_hs) begin
            out_valid_d = 1'b0;
        end
        // A new limb in the same cycle as consumption keeps out_valid high (back-to-back).
        if (in_hs) begin
            out_s_d     = csa_s;
            carry_d     = csa_co;
            out_valid_d = 1'b1;
            rem_d       = rem_q - ONE;
            out_last_d  = is_last;
            out_co_d    = is_last && csa_co;
            out_ovf_d   = is_last && (in_a[dataWidth-1] == b_eff[dataWidth-1])
                                  && (csa_s[dataWidth-1] != in_a[dataWidth-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            rem_q       <= '0;
            out_s_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_co_q    <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            rem_q       <= rem_d;
            out_s_q     <= out_s_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_co_q    <= out_co_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_s     = out_s_q;
    assign out_last  = out_last_q;
    assign out_co    = out_co_q;
    assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_csa_mp_seq.sv
// Directed bench for csa_mp_seq: expected result limbs are queued at stimulus time and checked as they leave.

module tb_csa_mp_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_sub;
    logic [3:0]  cmd_nlimbs;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [31:0] out_s;
    logic        out_last, out_co, out_ovf, busy;

    int total = 0;
    int bad   = 0;
    logic [34:0] exp_q[$];   // {s, last, co, ovf}

    always #5 clk = ~clk;

    csa_mp_seq #(.dataWidth(32), .nStage(4), .maxLimbs(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sub(cmd_sub), .cmd_nlimbs(cmd_nlimbs),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
        .out_last(out_last), .out_co(out_co), .out_ovf(out_ovf), .busy(busy)
    );

    // Scoreboard: every consumed output limb must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_out got s=%h last=%0b expected no output", out_s, out_last);
            end
            if (exp_q.size() != 0) begin
                logic [34:0] e;
                e = exp_q.pop_front();
                total++;
                assert ({out_s, out_last, out_co, out_ovf} === e) else begin
                    bad++;
                    $error("FAIL out_limb got s=%h last=%0b co=%0b ovf=%0b expected s=%h last=%0b co=%0b ovf=%0b",
                           out_s, out_last, out_co, out_ovf, e[34:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%h expected=%h", tag, got, expv);
        end
    endtask

    task automatic push_model(input logic sub, input int n, input logic [255:0] A, input logic [255:0] B);
        logic        c, co, last, ovf;
        logic [31:0] a, b, s;
        c = sub;
        for (int i = 0; i < n; i++) begin
            a    = A[i*32 +: 32];
            b    = B[i*32 +: 32] ^ {32{sub}};
            {co, s} = {1'b0, a} + {1'b0, b} + {32'd0, c};
            last = (i == n - 1);
            ovf  = last && (a[31] == b[31]) && (s[31] != a[31]);
            exp_q.push_back({s, last, last && co, ovf});
            c = co;
        end
    endtask

    task automatic send_cmd(input logic sub, input logic [3:0] nl);
        int   cnt = 0;
        logic hs  = 1'b0;
        cmd_sub = sub; cmd_nlimbs = nl; cmd_valid = 1'b1;
        while (!hs && cnt < 50) begin
            @(negedge clk); hs = cmd_ready;
            @(posedge clk); #1; cnt++;
        end
        cmd_valid = 1'b0;
        chk("cmd_hs", {31'd0, hs}, 32'd1);
    endtask

    task automatic send_limb(input logic [31:0] a, input logic [31:0] b);
        int   cnt = 0;
        logic hs  = 1'b0;
        in_a = a; in_b = b; in_valid = 1'b1;
        while (!hs && cnt < 50) begin
            @(negedge clk); hs = in_ready;
            @(posedge clk); #1; cnt++;
        end
        chk("in_hs", {31'd0, hs}, 32'd1);
    endtask

    task automatic wait_idle();
        int cnt = 0;
        in_valid = 1'b0;
        while ((busy || exp_q.size() != 0) && cnt < 200) begin
            @(posedge clk); #1; cnt++;
        end
        chk("drain_timeout", {31'd0, cnt < 200}, 32'd1);
    endtask

    task automatic run(input logic sub, input logic [3:0] nl, input logic [255:0] A, input logic [255:0] B);
        int n;
        n = (nl == 0) ? 1 : (nl > 8) ? 8 : int'(nl);
        push_model(sub, n, A, B);
        send_cmd(sub, nl);
        for (int i = 0; i < n; i++) send_limb(A[i*32 +: 32], B[i*32 +: 32]);
        wait_idle();
    endtask

    initial begin
        logic [255:0] A, B;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_sub = 1'b0; cmd_nlimbs = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_s", out_s, 32'd0);
        chk("rst_flags", {29'd0, out_last, out_co, out_ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // T1: carry ripples across two limbs
        exp_q.push_back({32'h0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({32'h0, 1'b1, 1'b1, 1'b0});
        send_cmd(1'b0, 4'd2);
        send_limb(32'hFFFF_FFFF, 32'h1);
        send_limb(32'hFFFF_FFFF, 32'h0);
        wait_idle();

        // T2: borrow out -> co=0
        exp_q.push_back({32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0});
        send_cmd(1'b1, 4'd1);
        send_limb(32'd5, 32'd7);
        wait_idle();

        // T3: signed overflow
        exp_q.push_back({32'h8000_0000, 1'b1, 1'b0, 1'b1});
        send_cmd(1'b0, 4'd1);
        send_limb(32'h7FFF_FFFF, 32'h1);
        wait_idle();

        // T4: four limbs with a three-cycle output stall after the second
        A = {128'd0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h1234_5678, 32'hF000_0000};
        B = {128'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h1111_1111, 32'h2000_0000};
        push_model(1'b0, 4, A, B);
        send_cmd(1'b0, 4'd4);
        send_limb(A[31:0], B[31:0]);
        send_limb(A[63:32], B[63:32]);
        out_ready = 1'b0;
        in_a = A[95:64]; in_b = B[95:64]; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_s", out_s, exp_q[0][34:3]);
            chk("run_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        send_limb(A[95:64], B[95:64]);
        send_limb(A[127:96], B[127:96]);
        wait_idle();

        // T5: limb-count clamping, plus a multi-limb subtract
        A = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        B = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run(1'b0, 4'd0, A, B);
        run(1'b0, 4'd15, A, B);
        run(1'b1, 4'd8, A, B);
        run(1'b1, 4'd3, B, A);
        chk("after_clamp_busy", {31'd0, busy}, 32'd0);
        chk("after_clamp_in_ready", {31'd0, in_ready}, 32'd0);

        // T6: reset after 2 of 4 limbs discards everything
        push_model(1'b0, 4, A, B);
        send_cmd(1'b0, 4'd4);
        send_limb(A[31:0], B[31:0]);
        send_limb(A[63:32], B[63:32]);
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_out_s", out_s, 32'd0);
        chk("mid_rst_flags", {29'd0, out_last, out_co, out_ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        exp_q.push_back({32'h0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({32'h0, 1'b1, 1'b1, 1'b0});
        send_cmd(1'b0, 4'd2);
        send_limb(32'hFFFF_FFFF, 32'h1);
        send_limb(32'hFFFF_FFFF, 32'h0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
